u_xmit_cfg: RTL
===============

Name: u_xmit_cfg

Overview:
- Parametrised successor to the existing fixed 8N1 UART transmitter.
- Serialises one word per ready/valid handshake with configurable data width and oversample ratio.
- Stop-bit count is selectable at run time; optional parity.
- Every bit cell is exactly OVS clocks. Supports back-to-back frames with no idle gap.
- Sits between the host-side command logic and the serial line pin, alongside the matching receiver.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- OVS, 16, sys_clk cycles per bit cell; legal 4..256.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- xmitH  in  1  valid: transmit request.
- xmit_dataH  in  DATA_W  word to send, LSB first.
- cfg_stop2H  in  1  0 = one stop bit, 1 = two stop bits.
- xmit_readyH  out  1  ready: block can accept a word this cycle.
- uart_xmitH  out  1  serial line, idle high; registered.
- busyH  out  1  high while a frame is on the line.
- xmit_doneH  out  1  one-cycle pulse after each frame completes.

Behaviour:
- Reset:
  - Asynchronous; outputs take their reset values immediately on assertion.
  - Reset values: uart_xmitH=1, xmit_readyH=1, busyH=0, xmit_doneH=0, state=IDLE, all counters 0.
  - Reset mid-frame aborts the frame: no done pulse, and the line is high from the assertion edge.
- Handshake:
  - Transfer occurs on a rising edge where xmitH && xmit_readyH.
  - On transfer, capture the data word and config (cfg_stop2H, plus parity config if compiled in).
  - Config changes after acceptance do not affect the frame in flight.
- xmit_readyH is high:
  - in IDLE; and
  - during the final cycle of the final stop bit.
  - It is low at all other times.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line=1. On transfer -> START.
  - START: line=0 for OVS cycles -> DATA.
  - DATA: line=shreg[0] for OVS cycles per bit; shift right after each cell. After DATA_W cells -> PARITY if enabled, else STOP.
  - PARITY: line=parity bit for OVS cycles -> STOP.
  - STOP: line=1 for OVS cycles per stop bit (1 or 2). At the last cycle: if a transfer occurs -> START, else -> IDLE.
- Latency:
  - For a transfer at edge T, uart_xmitH falls at edge T+1.
  - Frame length = (1 + DATA_W + P + S) x OVS cycles, where P = 0/1 (parity) and S = 1/2 (stop bits).
- Back-to-back: a transfer accepted in the last stop cycle starts the next START cell on the following edge, with no extra idle cycle.
- Counters:
  - Cell counter is clog2(OVS) bits and counts 0..OVS-1, wrapping to 0 at each cell boundary.
  - Bit counter is clog2(DATA_W+1) bits and is cleared on every transfer.
- busyH is high from edge T+1 through the last stop cycle. It stays high across back-to-back frames.
- xmit_doneH is registered and pulses for one cycle on the edge after each frame's last stop cycle, including back-to-back frames.
- xmitH while not ready is ignored; nothing is queued.

Optional Feature:
- Macro: U_XMIT_PARITY_EN.
- Defined:
  - Adds input ports cfg_par_enH (1 bit) and cfg_par_oddH (1 bit), both sampled at transfer.
  - When cfg_par_enH=1, a PARITY cell follows the data bits.
  - Parity bit = XOR of the DATA_W data bits, XOR cfg_par_oddH (even parity when 0, odd when 1).
- Undefined:
  - The ports and the PARITY state do not exist; P=0 always.
  - Logic is identical to the parity-disabled case.

Test Plan:
- DATA_W=8, OVS=16, stop1, data 0xA5 -> line holds 0,1,0,1,0,0,1,0,1,1, each for 16 cycles; frame = 160 cycles; xmit_doneH pulses once at cycle 161; xmit_readyH is high only at cycle 160.
- Same frame with cfg_stop2H=1 -> stop high for 32 cycles; frame = 176 cycles; cfg_stop2H toggled mid-frame has no effect.
- U_XMIT_PARITY_EN, cfg_par_enH=1, data 0xA5 (4 ones): cfg_par_oddH=0 -> parity cell 0; cfg_par_oddH=1 -> parity cell 1; frame = 176 cycles.
- xmitH held high with 0x3C then 0xC3 -> second START begins on the cycle immediately after the first frame's last stop cycle; 320 contiguous cycles; busyH never drops; two done pulses.
- sys_rst asserted at cycle 70 of a frame -> uart_xmitH=1 and xmit_readyH=1 immediately; no done pulse; next transfer produces a clean full frame.
- DATA_W=5, OVS=4, data 5'h13 -> 0,1,1,0,0,1,1 cells of 4 cycles each; frame = 28 cycles; bits above DATA_W are never driven.

Source files
------------

// File: rtl/u_xmit_cfg.sv
// Parametrised UART transmitter: DATA_W data bits, OVS clocks per bit cell, 1/2 stop bits.
// Optional parity cell compiled in with `define U_XMIT_PARITY_EN.
module u_xmit_cfg #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              xmitH,
    input  logic [DATA_W-1:0] xmit_dataH,
    input  logic              cfg_stop2H,
`ifdef U_XMIT_PARITY_EN
    input  logic              cfg_par_enH,
    input  logic              cfg_par_oddH,
`endif
    output logic              xmit_readyH,
    output logic              uart_xmitH,
    output logic              busyH,
    output logic              xmit_doneH
);

    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CELL_LAST = CW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef U_XMIT_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cell_q, cell_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              stop2_q, stop2_d;
    logic              stop_idx_q, stop_idx_d;
    logic              line_q, line_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef U_XMIT_PARITY_EN
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
`endif

    logic cell_last;
    logic stop_last;
    logic ready;
    logic xfer;

    assign cell_last = (cell_q == CELL_LAST);
    assign stop_last = cell_last && (stop_idx_q == stop2_q);
    assign ready     = (state_q == IDLE) || ((state_q == STOP) && stop_last);
    assign xfer      = xmitH && ready;

    always_comb begin
        state_d    = state_q;
        cell_d     = cell_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
`ifdef U_XMIT_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        if (state_q != IDLE) begin
            cell_d = cell_last ? '0 : cell_q + CW'(1);
        end

        case (state_q)
            IDLE: ;
            START: begin
                if (cell_last) state_d = DATA;
            end
            DATA: begin
                if (cell_last) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        stop_idx_d = 1'b0;
`ifdef U_XMIT_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef U_XMIT_PARITY_EN
            PARITY: begin
                if (cell_last) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (cell_last) begin
                    if (stop_idx_q != stop2_q) stop_idx_d = 1'b1;
                    else                       state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the STOP->IDLE exit so back-to-back frames have no gap.
        if (xfer) begin
            state_d    = START;
            cell_d     = '0;
            bit_d      = '0;
            shreg_d    = xmit_dataH;
            stop2_d    = cfg_stop2H;
            stop_idx_d = 1'b0;
`ifdef U_XMIT_PARITY_EN
            par_en_d   = cfg_par_enH;
            par_bit_d  = (^xmit_dataH) ^ cfg_par_oddH;
`endif
        end

        // Line is registered from the next state so it changes on the same edge as the FSM.
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shreg_d[0];
`ifdef U_XMIT_PARITY_EN
            PARITY:  line_d = par_bit_d;
`endif
            default: line_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && stop_last;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            cell_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef U_XMIT_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cell_q     <= cell_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef U_XMIT_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign xmit_readyH = ready;
    assign uart_xmitH  = line_q;
    assign busyH       = busy_q;
    assign xmit_doneH  = done_q;

endmodule
